// File: rtl/pll_reconfig_sched_pkg.sv
// pll_sched_pkg -- shared types and constants for the PLL reconfiguration
// scheduler.
//   sched_state_t : scheduler FSM states (also exported as a debug output)
//   rsp_status_t  : result code returned with each ack pulse
//   LOCK_STABLE_CYCLES : consecutive synchronized-lock cycles required for OK
//   FACTOR_W      : width of the multiply / divide factors
//   N_REQ         : number of requesters
package pll_sched_pkg;

  localparam int LOCK_STABLE_CYCLES = 4;
  localparam int FACTOR_W           = 8;
  localparam int N_REQ              = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    TRIG      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    WAIT_LOCK = 3'd5,
    RESP      = 3'd6
  } sched_state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_BAD_ARG = 2'd1,
    RSP_TO_BUSY = 2'd2,
    RSP_TO_LOCK = 2'd3
  } rsp_status_t;

endpackage

// File: rtl/pll_reconfig_sched_if.sv
// pll_reconfig_sched_if -- requester-side bus of the PLL reconfiguration
// scheduler.
//   req        : per-requester request level
//   req_mult   : per-requester multiply factor
//   req_div    : per-requester divide factor
//   ack        : per-requester one-cycle completion pulse
//   rsp_status : result code, meaningful only in the ack cycle
//
// Handshake: a requester raises req[i] with req_mult[i]/req_div[i] stable and
// keeps them until it sees ack[i]; ack[i] is a single-cycle pulse carrying
// rsp_status, after which the requester drops req[i] (or keeps it high to
// issue a new request). Once granted, a transaction always ends in an ack,
// even if req[i] is dropped early.
interface pll_reconfig_sched_if;
  import pll_sched_pkg::*;

  logic [N_REQ-1:0]               req;
  logic [N_REQ-1:0][FACTOR_W-1:0] req_mult;
  logic [N_REQ-1:0][FACTOR_W-1:0] req_div;
  logic [N_REQ-1:0]               ack;
  logic [1:0]                     rsp_status;

  modport master (output req, req_mult, req_div, input ack, rsp_status);
  modport slave  (input req, req_mult, req_div, output ack, rsp_status);

endinterface

// File: rtl/pll_reconfig_sched_rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter.
//   clk, rst  : clock, asynchronous active-high reset
//   req_i     : request vector
//   accept_i  : the current grant is taken; rotate priority
//   gnt_o     : one-hot grant (zero when no request)
// After reset requester 0 has priority; an accepted grant hands priority to
// the other requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // Requester that wins when both request.
  logic prio_q, prio_d;

  always_comb begin
    gnt_o = 2'b00;
    if (prio_q == 1'b0) begin
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
    end else begin
      if (req_i[1])      gnt_o = 2'b10;
      else if (req_i[0]) gnt_o = 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (accept_i && gnt_o[0])      prio_d = 1'b1;
    else if (accept_i && gnt_o[1]) prio_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/pll_reconfig_sched.sv
// pll_reconfig_sched -- arbitrates reconfiguration requests from two clients
// and sequences the PLL_INTERFACE handshake (trigger, busy, lock).
//   clock, reset    : system clock, asynchronous active-high reset
//   bus             : requester bus (req / factors in, ack / rsp_status out)
//   trigger         : reconfiguration start pulse, TRIG_CYCLES wide
//   MultiFactor     : multiply factor presented to PLL_INTERFACE
//   DividFactor     : divide factor presented to PLL_INTERFACE
//   busy            : PLL_INTERFACE reconfiguration in progress
//   locked          : PLL lock, asynchronous to clock
//   sched_busy      : high whenever the FSM is not idle
//   dbg_state_o     : current FSM state
module pll_reconfig_sched
  import pll_sched_pkg::*;
#(
  parameter int TRIG_CYCLES    = 5,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  pll_reconfig_sched_if.slave   bus,
  output logic                  trigger,
  output logic [FACTOR_W-1:0]   MultiFactor,
  output logic [FACTOR_W-1:0]   DividFactor,
  input  logic                  busy,
  input  logic                  locked,
  output logic                  sched_busy,
  output sched_state_t          dbg_state_o
);

  localparam logic [15:0] TRIG_LAST    = 16'(TRIG_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LOCK_LAST    = 3'(LOCK_STABLE_CYCLES - 1);

  sched_state_t        state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [FACTOR_W-1:0] lm_q, lm_d, ld_q, ld_d;
  logic [FACTOR_W-1:0] mf_q, mf_d, df_q, df_d;
  rsp_status_t         status_q, status_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [2:0]          lock_cnt_q, lock_cnt_d;
  logic [1:0]          lock_sync_q;
  logic                locked_s;

  logic [N_REQ-1:0]    arb_gnt;
  logic                arb_accept;
  logic [FACTOR_W-1:0] sel_mult, sel_div;

  assign locked_s = lock_sync_q[1];

  rr_arb2 u_arb (
    .clk      (clock),
    .rst      (reset),
    .req_i    (bus.req),
    .accept_i (arb_accept),
    .gnt_o    (arb_gnt)
  );

  // AND-OR mux of the granted requester's factors (grant is one-hot).
  always_comb begin
    sel_mult = '0;
    sel_div  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_mult = sel_mult | bus.req_mult[i];
        sel_div  = sel_div  | bus.req_div[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    lm_d       = lm_q;
    ld_d       = ld_q;
    mf_d       = mf_q;
    df_d       = df_q;
    status_d   = status_q;
    lock_cnt_d = lock_cnt_q;
    arb_accept = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          arb_accept = 1'b1;
          gnt_d      = arb_gnt;
          lm_d       = sel_mult;
          ld_d       = sel_div;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (lm_q == '0 || ld_q == '0) begin
          status_d = RSP_BAD_ARG;
          state_d  = RESP;
        end else if (lm_q == mf_q && ld_q == df_q && locked_s) begin
          // PLL already running at these factors: nothing to do.
          status_d = RSP_OK;
          state_d  = RESP;
        end else begin
          mf_d    = lm_q;
          df_d    = ld_q;
          state_d = TRIG;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          status_d = RSP_TO_BUSY;
          state_d  = RESP;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == TIMEOUT_LAST) begin
          status_d = RSP_TO_BUSY;
          state_d  = RESP;
        end
      end
      WAIT_LOCK: begin
        if (locked_s && lock_cnt_q == LOCK_LAST) begin
          status_d = RSP_OK;
          state_d  = RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          status_d = RSP_TO_LOCK;
          state_d  = RESP;
        end else if (locked_s) begin
          lock_cnt_d = lock_cnt_q + 3'd1;
        end else begin
          lock_cnt_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Phase timer and lock-run counter restart on every state change; the
    // timer saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d      = '0;
      lock_cnt_d = '0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      lm_q        <= '0;
      ld_q        <= '0;
      mf_q        <= FACTOR_W'(1);
      df_q        <= FACTOR_W'(1);
      status_q    <= RSP_OK;
      cnt_q       <= '0;
      lock_cnt_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lm_q        <= lm_d;
      ld_q        <= ld_d;
      mf_q        <= mf_d;
      df_q        <= df_d;
      status_q    <= status_d;
      cnt_q       <= cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      lock_sync_q <= {lock_sync_q[0], locked};
    end
  end

  // Decoded straight from the state register so that reset clears trigger,
  // ack and sched_busy without waiting for a clock edge.
  always_comb begin
    bus.ack = '0;
    if (state_q == RESP) bus.ack = gnt_q;
  end

  assign bus.rsp_status = status_q;
  assign trigger        = (state_q == TRIG);
  assign MultiFactor    = mf_q;
  assign DividFactor    = df_q;
  assign sched_busy     = (state_q != IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: doc/pll_reconfig_sched.md
PLL_RECONFIG_SCHED -- requirements
Module: pll_reconfig_sched

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 5, trigger pulse width in clock cycles (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, per-phase wait limit in clock cycles (16..65535).
REQ-003 SHALL have port clock  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  2  per-requester reconfiguration request, level, held until ack.
REQ-006 SHALL have port req_mult  input  2x8  per-requester multiply factor, stable while req is high.
REQ-007 SHALL have port req_div  input  2x8  per-requester divide factor, stable while req is high.
REQ-008 SHALL have port ack  output  2  per-requester one-cycle completion pulse.
REQ-009 SHALL have port rsp_status  output  2  result code, valid in the ack cycle: 0 OK, 1 BAD_ARG, 2 TO_BUSY, 3 TO_LOCK.
REQ-010 SHALL have port trigger  output  1  reconfiguration start to PLL_INTERFACE.
REQ-011 SHALL have port MultiFactor  output  8  multiply factor to PLL_INTERFACE.
REQ-012 SHALL have port DividFactor  output  8  divide factor to PLL_INTERFACE.
REQ-013 SHALL have port busy  input  1  PLL_INTERFACE reconfiguration in progress.
REQ-014 SHALL have port locked  input  1  PLL lock indication; treated as asynchronous.
REQ-015 SHALL have port sched_busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, CHECK, TRIG, WAIT_BUSY, WAIT_DONE, WAIT_LOCK, RESP.
REQ-017 IDLE: if any req is high, SHALL grant one requester round-robin (last-granted gets lowest priority; requester 0 is first after reset), latch its factors, and go to CHECK.
REQ-018 CHECK (1 cycle): factor zero -> RESP with BAD_ARG, PLL outputs untouched; factors equal to MultiFactor/DividFactor with synchronized locked high -> RESP with OK (skip); otherwise load MultiFactor/DividFactor and go to TRIG.
REQ-019 TRIG: trigger SHALL be high for exactly TRIG_CYCLES cycles, MultiFactor/DividFactor already stable in the first one, then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: busy high -> WAIT_DONE; TIMEOUT_CYCLES without it -> RESP with TO_BUSY.
REQ-021 WAIT_DONE: busy low -> WAIT_LOCK; timeout -> RESP with TO_BUSY.
REQ-022 WAIT_LOCK: synchronized locked high for 4 consecutive cycles -> RESP with OK; timeout -> RESP with TO_LOCK.
REQ-023 The timeout counter SHALL be 16 bits, clear on every state entry, and saturate, never wrap.
REQ-024 RESP (1 cycle): ack SHALL pulse for the granted requester only, with rsp_status, then go to IDLE; the next grant is no earlier than the following cycle.
REQ-025 After a grant, the transaction SHALL complete and ack SHALL pulse even if that req drops; requests in other states SHALL wait, not be lost.
REQ-026 Both req high in IDLE SHALL grant one requester; the other SHALL be granted on the next IDLE visit.
REQ-027 locked SHALL pass through a 2-flop synchronizer before use.

Reset
REQ-028 On reset: state IDLE, ack 0, rsp_status 0, trigger 0, MultiFactor 1, DividFactor 1, sched_busy 0, round-robin pointer to requester 0, counters 0.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately with no ack; trigger SHALL drop asynchronously.

Structure
REQ-030 Package pll_sched_pkg SHALL hold the state enum, the rsp_status enum, and constants LOCK_STABLE_CYCLES=4 and FACTOR_W=8.
REQ-031 The 2-way round-robin arbiter SHALL be a sub-module rr_arb2 with request, grant, and a pointer update on accept.

Verification
REQ-032 req[0] with 6/3, behavioral PLL (busy 20 cycles, locked 50 cycles after) -> trigger high 5 cycles, MultiFactor=6, DividFactor=3, ack[0] with OK.
REQ-033 req[0] and req[1] raised together with 8/8 and 20/2 -> ack[0] OK first, then req[1] serviced, MultiFactor=20, DividFactor=2, ack[1] OK; next dual request grants requester 0 after requester 1.
REQ-034 req[1] with 0/20 -> ack[1] with BAD_ARG in ≤3 cycles, trigger never high, factors unchanged.
REQ-035 req with 2/20, PLL model never asserts busy -> ack with TO_BUSY after 4096 cycles in WAIT_BUSY; locked held low after busy -> TO_LOCK.
REQ-036 Repeat of current 2/20 while locked -> ack OK, no trigger pulse.
REQ-037 reset pulsed during WAIT_LOCK -> no ack, all outputs at reset values; a subsequent request completes normally.
